// File: rtl/benes_sched_pkg.sv
// Shared types and size helpers for the Benes network scheduler.
package benes_sched_pkg;

  localparam int MAX_IDX_W = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } state_e;

  typedef logic [MAX_IDX_W-1:0] cfg_idx_t;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] req_id;
  } pipe_entry_t;

  function automatic int stages(input int size);
    return 2 * $clog2(size) - 1;
  endfunction

  function automatic int bitwidth(input int size);
    return stages(size) * (size / 2);
  endfunction

  function automatic int lat(input int size);
    return stages(size) - 1;
  endfunction

endpackage

// File: rtl/benes_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr wins.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/benes_sched.sv
// Shares one pipelined Benes network among NREQ requesters, draining in-flight
// beats before any control-vector change and tagging each output beat.
module benes_sched
  import benes_sched_pkg::*;
#(
  parameter  int SIZE     = 32,
  parameter  int DWIDTH   = 16,
  parameter  int NREQ     = 4,
  parameter  int NCFG     = 4,
  localparam int BITWIDTH = bitwidth(SIZE),
  localparam int LAT      = lat(SIZE),
  localparam int CW       = (NCFG > 1) ? $clog2(NCFG) : 1,
  localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   cfg_wen,
  input  logic [CW-1:0]                          cfg_waddr,
  input  logic [BITWIDTH-1:0]                    cfg_wdata,
  input  logic [NREQ-1:0]                        req_valid,
  input  logic [NREQ-1:0][CW-1:0]                req_cfg,
  input  logic [NREQ-1:0][SIZE-1:0][DWIDTH-1:0]  req_data,
  output logic [NREQ-1:0]                        req_ready,
  output logic [SIZE-1:0][DWIDTH-1:0]            net_in,
  output logic                                   net_issue,
  output logic [BITWIDTH-1:0]                    net_ctrl,
  output logic                                   out_valid,
  output logic [IW-1:0]                          out_req_id,
  output logic                                   busy
);

  state_e              state;
  logic                active_valid;
  logic [CW-1:0]       active_cfg;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       pending;
  logic [BITWIDTH-1:0] cfg_table [NCFG];
  pipe_entry_t         pipe [LAT];

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   widx;
  logic            any_req;
  logic            match;
  logic            accept;
  logic            mismatch;
  logic            pipe_empty;
  logic [CW-1:0]   win_cfg;
  logic [CW-1:0]   load_cfg;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (widx),
    .any       (any_req)
  );

  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      if (pipe[i].valid) pipe_empty = 1'b0;
    end
  end

  assign win_cfg    = req_cfg[widx];
  assign load_cfg   = req_cfg[pending];
  assign match      = any_req && active_valid && (win_cfg == active_cfg);
  assign mismatch   = (state == RUN) && any_req && !match;
  assign accept     = (state == RUN) && match;
  assign req_ready  = accept ? grant : '0;
  assign net_issue  = accept;
  assign net_in     = req_data[widx];
  assign out_valid  = pipe[LAT-1].valid;
  assign out_req_id = pipe[LAT-1].req_id[IW-1:0];
  assign busy       = (state != RUN) || !pipe_empty;

  // Control: FSM, active config tracking, RR pointer
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= RUN;
      active_valid <= 1'b0;
      active_cfg   <= '0;
      net_ctrl     <= '0;
      rr_ptr       <= '0;
    end else begin
      if (accept) rr_ptr <= (widx == IW'(NREQ - 1)) ? '0 : widx + IW'(1);
      unique case (state)
        RUN:     if (mismatch) state <= pipe_empty ? SWITCH : DRAIN;
        DRAIN:   if (pipe_empty) state <= SWITCH;
        SWITCH:  state <= RUN;
        default: state <= RUN;
      endcase
      // A write racing the load keeps the old word in net_ctrl but forces a reload
      if (state == SWITCH) begin
        net_ctrl     <= cfg_table[load_cfg];
        active_cfg   <= load_cfg;
        active_valid <= !(cfg_wen && (cfg_waddr == load_cfg));
      end else if (cfg_wen && (cfg_idx_t'(cfg_waddr) == cfg_idx_t'(active_cfg))) begin
        active_valid <= 1'b0;
      end
    end
  end

  // Stage 0 .. LAT-1: valid/requester-id shadow of the network pipeline
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: net_issue, req_id: MAX_IDX_W'(widx)};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (cfg_wen) cfg_table[cfg_waddr] <= cfg_wdata;
    if (mismatch) pending <= widx;
  end

endmodule

// File: tb/tb_benes_sched.sv
// Directed bench for benes_sched: cold start, streaming, drain/switch, table hazards, fairness, reset.
module tb_benes_sched;

  localparam int SIZE   = 32;
  localparam int DWIDTH = 16;
  localparam int NREQ   = 4;
  localparam int NCFG   = 4;
  localparam int BW     = 9 * (SIZE / 2);
  localparam int CW     = 2;
  localparam int IW     = 2;

  logic                                  CLK = 1'b0;
  logic                                  RST;
  logic                                  cfg_wen;
  logic [CW-1:0]                         cfg_waddr;
  logic [BW-1:0]                         cfg_wdata;
  logic [NREQ-1:0]                       req_valid;
  logic [NREQ-1:0][CW-1:0]               req_cfg;
  logic [NREQ-1:0][SIZE-1:0][DWIDTH-1:0] req_data;
  logic [NREQ-1:0]                       req_ready;
  logic [SIZE-1:0][DWIDTH-1:0]           net_in;
  logic                                  net_issue;
  logic [BW-1:0]                         net_ctrl;
  logic                                  out_valid;
  logic [IW-1:0]                         out_req_id;
  logic                                  busy;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  benes_sched #(.SIZE(SIZE), .DWIDTH(DWIDTH), .NREQ(NREQ), .NCFG(NCFG)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .cfg_wen    (cfg_wen),
    .cfg_waddr  (cfg_waddr),
    .cfg_wdata  (cfg_wdata),
    .req_valid  (req_valid),
    .req_cfg    (req_cfg),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .net_in     (net_in),
    .net_issue  (net_issue),
    .net_ctrl   (net_ctrl),
    .out_valid  (out_valid),
    .out_req_id (out_req_id),
    .busy       (busy)
  );

  function automatic logic [SIZE*DWIDTH-1:0] lanes(input int r);
    logic [SIZE*DWIDTH-1:0] v;
    v = '0;
    for (int l = 0; l < SIZE; l++) v[l*DWIDTH +: DWIDTH] = DWIDTH'(16'h1000 + r * 256 + l);
    return v;
  endfunction

  function automatic logic [BW-1:0] cw(input int slot, input int gen);
    logic [15:0] w;
    w = {8'(gen), 8'(slot)};
    return {9{w}};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int exp2 [6];
    int got;
    logic [NREQ-1:0] oh;
    exp2 = '{1, 2, 0, 1, 2, 0};

    RST       = 1'b1;
    cfg_wen   = 1'b0;
    cfg_waddr = '0;
    cfg_wdata = '0;
    req_valid = '0;
    req_cfg   = '0;
    for (int r = 0; r < NREQ; r++) req_data[r] = lanes(r);
    tick();
    tick();
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_issue", net_issue, 0);
    chk("rst_ctrl", net_ctrl, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_id", out_req_id, 0);
    chk("rst_busy", busy, 0);

    tick();
    RST = 1'b0;
    for (int k = 0; k < NCFG; k++) begin
      cfg_wen   = 1'b1;
      cfg_waddr = CW'(k);
      cfg_wdata = cw(k, 1);
      tick();
    end

    // Cold start: cycle A
    cfg_wen    = 1'b0;
    req_valid  = 4'b0001;
    req_cfg[0] = 2'd2;
    #1;
    chk("cold_a0_ready", req_ready, 0);
    chk("cold_a0_issue", net_issue, 0);
    chk("cold_a0_busy", busy, 0);
    tick(); #1;
    chk("cold_switch_ready", req_ready, 0);
    chk("cold_switch_busy", busy, 1);
    tick(); #1;
    chk("cold_accept_ready", req_ready, 4'b0001);
    chk("cold_accept_issue", net_issue, 1);
    chk("cold_net_in", net_in, lanes(0));
    chk("cold_ctrl", net_ctrl, cw(2, 1));
    tick();
    req_valid = '0;
    repeat (6) tick();
    #1;
    chk("cold_out_early", out_valid, 0);
    tick(); #1;
    chk("cold_out_valid", out_valid, 1);
    chk("cold_out_id", out_req_id, 0);
    tick(); #1;
    chk("cold_out_after", out_valid, 0);
    chk("cold_idle_busy", busy, 0);

    // Back-to-back same config: cycle B
    tick();
    req_valid = 4'b0111;
    req_cfg[0] = 2'd1;
    req_cfg[1] = 2'd1;
    req_cfg[2] = 2'd1;
    #1;
    chk("b2b_mismatch_ready", req_ready, 0);
    tick(); #1;
    chk("b2b_switch_ready", req_ready, 0);
    for (int k = 0; k < 6; k++) begin
      tick(); #1;
      oh = NREQ'(1) << exp2[k];
      chk("b2b_ready", req_ready, oh);
      chk("b2b_net_in", net_in, lanes(exp2[k]));
      chk("b2b_ctrl", net_ctrl, cw(1, 1));
    end
    tick();
    req_valid = '0;
    tick(); #1;
    chk("b2b_out_early", out_valid, 0);
    for (int k = 0; k < 6; k++) begin
      tick(); #1;
      chk("b2b_out_valid", out_valid, 1);
      chk("b2b_out_id", out_req_id, exp2[k]);
    end
    tick(); #1;
    chk("b2b_out_done", out_valid, 0);

    // Config switch with drain: cycle C
    tick();
    req_valid = 4'b0001;
    req_cfg[0] = 2'd1;
    #1;
    chk("drain_c0_ready", req_ready, 4'b0001);
    tick(); #1;
    chk("drain_c1_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0011;
    req_cfg[1] = 2'd3;
    #1;
    chk("drain_mismatch_ready", req_ready, 0);
    tick(); #1;
    chk("drain_hold_ready", req_ready, 0);
    chk("drain_busy", busy, 1);
    repeat (5) tick();
    #1;
    chk("drain_out0_valid", out_valid, 1);
    chk("drain_out0_id", out_req_id, 0);
    tick(); #1;
    chk("drain_out1_valid", out_valid, 1);
    chk("drain_out1_ctrl", net_ctrl, cw(1, 1));
    tick(); #1;
    chk("drain_empty_out", out_valid, 0);
    chk("drain_empty_ready", req_ready, 0);
    tick(); #1;
    chk("drain_switch_ready", req_ready, 0);
    chk("drain_switch_ctrl", net_ctrl, cw(1, 1));
    tick(); #1;
    chk("drain_req1_ready", req_ready, 4'b0010);
    chk("drain_req1_ctrl", net_ctrl, cw(3, 1));
    chk("drain_req1_net_in", net_in, lanes(1));
    tick();
    req_valid = '0;
    repeat (7) tick();
    #1;
    chk("drain_req1_out_valid", out_valid, 1);
    chk("drain_req1_out_id", out_req_id, 1);

    // Rewrite active slot while a beat is in flight: cycle D
    tick();
    req_valid  = 4'b0100;
    req_cfg[2] = 2'd3;
    cfg_wen    = 1'b1;
    cfg_waddr  = 2'd3;
    cfg_wdata  = cw(3, 2);
    #1;
    chk("hz_accept_ready", req_ready, 4'b0100);
    tick();
    cfg_wen = 1'b0;
    #1;
    chk("hz_invalidated_ready", req_ready, 0);
    chk("hz_ctrl_kept", net_ctrl, cw(3, 1));
    repeat (7) tick();
    #1;
    chk("hz_out_valid", out_valid, 1);
    chk("hz_out_id", out_req_id, 2);
    chk("hz_out_ctrl", net_ctrl, cw(3, 1));
    tick();
    tick(); #1;
    chk("hz_switch_ready", req_ready, 0);
    tick(); #1;
    chk("hz_reload_ready", req_ready, 4'b0100);
    chk("hz_reload_ctrl", net_ctrl, cw(3, 2));
    tick();
    req_valid = '0;
    repeat (9) tick();

    // Write lands in the SWITCH cycle: cycle E
    req_valid  = 4'b1000;
    req_cfg[3] = 2'd0;
    #1;
    chk("sw_mismatch_ready", req_ready, 0);
    tick();
    cfg_wen   = 1'b1;
    cfg_waddr = 2'd0;
    cfg_wdata = cw(0, 2);
    #1;
    chk("sw_switch1_ready", req_ready, 0);
    tick();
    cfg_wen = 1'b0;
    #1;
    chk("sw_run_ready", req_ready, 0);
    chk("sw_old_word", net_ctrl, cw(0, 1));
    tick(); #1;
    chk("sw_switch2_ready", req_ready, 0);
    tick(); #1;
    chk("sw_accept_ready", req_ready, 4'b1000);
    chk("sw_new_word", net_ctrl, cw(0, 2));

    // Fairness between two configs: cycle F
    tick();
    req_valid  = 4'b0011;
    req_cfg[0] = 2'd0;
    req_cfg[1] = 2'd1;
    #1;
    chk("fair_f0_ready", req_ready, 4'b0001);
    got = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(); #1;
      if (req_ready[1]) begin
        got = i;
        break;
      end
    end
    chk("fair_req1_wait", got, 11);
    got = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(); #1;
      if (req_ready[0]) begin
        got = i;
        break;
      end
    end
    chk("fair_req0_wait", got, 11);
    tick();
    req_valid = '0;

    // Mid-run reset: cycle G
    tick();
    req_valid  = 4'b0001;
    req_cfg[0] = 2'd0;
    #1;
    chk("mrst_accept_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("mrst_ready", req_ready, 0);
    chk("mrst_issue", net_issue, 0);
    chk("mrst_ctrl", net_ctrl, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_id", out_req_id, 0);
    chk("mrst_busy", busy, 0);
    for (int i = 0; i < 9; i++) begin
      tick(); #1;
      chk("mrst_no_out", out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/benes_sched.md
Name: benes_sched

Overview:
- Scheduler and configurator for the pipelined Benes permutation network.
- Shares one network instance among NREQ requesters. Holds a table of NCFG permutation control words. Drives the network data input, the control vector and an issue strobe.
- The network applies a single control vector to all stages at once. The block therefore drains in-flight beats before switching permutation, and tags each output beat with the requester that issued it.

Parameters:
- SIZE, 32, network lanes (power of two).
- DWIDTH, 16, bits per lane.
- NREQ, 4, number of requesters.
- NCFG, 4, config table entries.
- TAGWIDTH, $clog2(SIZE), derived.
- STAGES, 2*TAGWIDTH-1, derived.
- BITWIDTH, STAGES*(SIZE/2), control vector width, derived.
- LAT, STAGES-1, network input-to-output latency in cycles (8 at SIZE=32), derived.

Ports:
- CLK  in  1  clock; single clock domain.
- RST  in  1  reset, synchronous, active-high.
- cfg_wen  in  1  config table write enable.
- cfg_waddr  in  $clog2(NCFG)  table slot to write.
- cfg_wdata  in  BITWIDTH  control word to write.
- req_valid  in  NREQ  per-requester request valid.
- req_cfg  in  NREQ x $clog2(NCFG)  config slot each requester needs.
- req_data  in  NREQ x SIZE x DWIDTH  lane vectors to permute.
- req_ready  out  NREQ  one-hot accept; transfer when valid&&ready.
- net_in  out  SIZE x DWIDTH  muxed winner data to the network input.
- net_issue  out  1  beat presented on net_in this cycle.
- net_ctrl  out  BITWIDTH  registered control vector to the network.
- out_valid  in-pipe  out  1  network output beat valid.
- out_req_id  out  $clog2(NREQ)  requester that owns the current output beat.
- busy  out  1  state != RUN or pipeline non-empty.

Behaviour:
- Reset values: state=RUN, active_valid=0, active_cfg=0, net_ctrl=0, rr_ptr=0, valid/ID shift pipe all 0, req_ready=0, net_issue=0, out_valid=0, out_req_id=0. The config table is not reset.
- Pipe: LAT-deep shift register of {valid, req_id}. Stage 0 loads {net_issue, winner}. out_valid/out_req_id come from the last stage. A beat accepted in cycle t appears on out_valid in cycle t+LAT.
- pipe_empty: all pipe valid bits are 0, including the output stage.
- Arbitration: round-robin over req_valid, starting at rr_ptr. rr_ptr advances to winner+1 (mod NREQ) only on an accept. The winner is recomputed every cycle in RUN; no lock.
- RUN:
  - Winner with active_valid && req_cfg==active_cfg: req_ready[winner]=1, net_issue=1, net_in=req_data[winner]. This is a combinational mux; the cycle is the same as the accept.
  - Winner mismatches and pipe_empty: next state SWITCH, with no accept.
  - Winner mismatches and pipe not empty: next state DRAIN, with no accept.
  - No valid requesters: stay in RUN.
- DRAIN:
  - No accepts for any requester, including ones matching active_cfg. This guarantees starvation freedom.
  - On pipe_empty, go to SWITCH.
- SWITCH (1 cycle):
  - No accept.
  - At the cycle edge: net_ctrl <= table[req_cfg[pending]], active_cfg <= req_cfg[pending], active_valid <= 1. Then go to RUN.
  - pending = RR winner latched at the mismatch decision.
  - If the pending requester drops req_valid before SWITCH, the load still completes, and RUN re-arbitrates.
- net_ctrl changes only in SWITCH, which only follows pipe_empty. No in-flight beat ever sees a control change. This covers the combinational first and last network stages.
- Config writes:
  - The table is written at the cycle edge.
  - A write to slot active_cfg sets active_valid<=0, and the next request for that slot triggers a switch.
  - A write to the slot being loaded in the same SWITCH cycle: net_ctrl takes the old word, active_valid ends 0. The write wins and a reload is forced.
- Cold start: after reset, active_valid=0. The first request takes RUN(mismatch, empty) -> SWITCH -> RUN and is accepted 2 cycles after req_valid rises.
- RST mid-operation: the pipe is cleared, and in-flight beats are discarded with no out_valid.

Decomposition:
- Package benes_sched_pkg:
  - state enum {RUN, DRAIN, SWITCH}.
  - Functions for stages(size), bitwidth(size), lat(size).
  - Pipe entry struct {valid, req_id}.
  - Config index typedef.
- Sub-module rr_arbiter #(N): inputs req[N], ptr; outputs grant one-hot, grant_idx, any. Combinational.
- Parent owns the FSM, table, pipe and data mux.

Test Plan:
- Cold start: after reset, req0 valid with cfg 2 at cycle 0 -> SWITCH at cycle 1, accept at cycle 2, net_ctrl==table[2] from cycle 2, out_valid with out_req_id=0 at cycle 10 (SIZE=32).
- Back-to-back same config: req0/req1/req2 all with cfg 1 held valid -> accepts every cycle in order 0,1,2,0,… No bubbles, and out_req_id follows the same order LAT cycles later.
- Config switch with drain: req0 cfg 1 streaming, req1 raises cfg 3 -> req1 wins its RR slot, accepts stop, DRAIN lasts until the last beat exits, then SWITCH, then req1 accepted. Checker: net_ctrl is stable whenever any pipe valid is set.
- Fairness: req0 cfg 0 held valid with req1 cfg 1 toggling -> neither requester waits more than NREQ arbitration rounds plus the drain time (LAT+2 cycles).
- Table rewrite hazard: write slot active_cfg while beats are in flight -> in-flight output is unaffected, and the next request for that slot forces SWITCH and loads the new word. Repeat with the write landing in the SWITCH cycle: a second SWITCH must follow.
- Mid-run reset: RST asserted 3 cycles after an accept -> the following cycle has all outputs at reset values, and no out_valid occurs for the discarded beat.
